// File: rtl/tpu_sram_loader.sv
// Purpose: streams 64-bit host beats into the weight SRAM, then unpacks bytes into the vector SRAM, then kicks tpu_top.
// Latency: each SRAM write appears one cycle after its handshake; tpu_start follows the last vector write by one cycle.
// Backpressure: in_ready is high every cycle of LOAD_W, and once per 8 cycles in LOAD_V while a beat is unpacked.
// Build option: LOADER_VBYTE_MSB_FIRST_EN puts the beat's top byte at the lowest vector address (default is low byte first).
module tpu_sram_loader #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int W_DEPTH         = 64,
  parameter int V_DEPTH         = 32,
  parameter int W_ADDR_WIDTH    = 6,
  parameter int V_ADDR_WIDTH    = 5
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       load_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SRAM_DATA_WIDTH-1:0] in_data,
  output logic                       sram_write_enable_w,
  output logic [W_ADDR_WIDTH-1:0]    sram_waddr_w,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata_w,
  output logic                       sram_write_enable_v,
  output logic [V_ADDR_WIDTH-1:0]    sram_waddr_v,
  output logic [DATA_WIDTH-1:0]      sram_wdata_v,
  output logic                       tpu_start,
  input  logic                       tpu_done,
  output logic                       busy,
  output logic                       load_done
);

  localparam int BYTES = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int RW    = $clog2(BYTES + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_V, START, WAIT_DONE} state_t;

  state_t                      state, state_nxt;
  logic [W_ADDR_WIDTH-1:0]     w_cnt;
  logic [V_ADDR_WIDTH-1:0]     v_cnt;
  logic [SRAM_DATA_WIDTH-1:0]  vbuf_dat;
  logic [RW-1:0]               vbuf_left;
  logic                        w_hs, w_last_hs, v_hs, v_last_wr, vbuf_empty;
  logic [DATA_WIDTH-1:0]       in_byte, buf_byte;
  logic [SRAM_DATA_WIDTH-1:0]  in_rest, buf_rest;

  // Byte order of the unpack: the emitted byte sits at one end, the rest shifts toward it.
`ifdef LOADER_VBYTE_MSB_FIRST_EN
  assign in_byte  = in_data[SRAM_DATA_WIDTH-1 -: DATA_WIDTH];
  assign buf_byte = vbuf_dat[SRAM_DATA_WIDTH-1 -: DATA_WIDTH];
  assign in_rest  = in_data << DATA_WIDTH;
  assign buf_rest = vbuf_dat << DATA_WIDTH;
`else
  assign in_byte  = in_data[DATA_WIDTH-1:0];
  assign buf_byte = vbuf_dat[DATA_WIDTH-1:0];
  assign in_rest  = in_data >> DATA_WIDTH;
  assign buf_rest = vbuf_dat >> DATA_WIDTH;
`endif

  // The final vector byte is on the bus this cycle; no further beat may be taken.
  assign v_last_wr  = sram_write_enable_v && (sram_waddr_v == V_ADDR_WIDTH'(V_DEPTH - 1));
  assign vbuf_empty = (vbuf_left == '0);
  assign w_hs       = (state == LOAD_W) && in_valid;
  assign w_last_hs  = w_hs && (w_cnt == W_ADDR_WIDTH'(W_DEPTH - 1));
  assign v_hs       = (state == LOAD_V) && in_valid && vbuf_empty && !v_last_wr;
  assign in_ready   = (state == LOAD_W) || ((state == LOAD_V) && vbuf_empty && !v_last_wr);
  assign busy       = (state != IDLE);

  // State register; srst aborts any load immediately.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode plus the single-cycle start/done pulses.
  always_comb begin
    state_nxt = state;
    tpu_start = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE:      if (load_start) state_nxt = LOAD_W;
      LOAD_W:    if (w_last_hs) state_nxt = LOAD_V;
      LOAD_V:    if (v_last_wr) state_nxt = START;
      START: begin
        tpu_start = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (tpu_done) begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Counters, unpack buffer and registered SRAM write ports.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      w_cnt               <= '0;
      v_cnt               <= '0;
      vbuf_dat            <= '0;
      vbuf_left           <= '0;
      sram_write_enable_w <= 1'b0;
      sram_waddr_w        <= '0;
      sram_wdata_w        <= '0;
      sram_write_enable_v <= 1'b0;
      sram_waddr_v        <= '0;
      sram_wdata_v        <= '0;
    end else begin
      sram_write_enable_w <= w_hs;
      sram_write_enable_v <= 1'b0;
      if ((state == IDLE) && load_start) begin
        w_cnt     <= '0;
        v_cnt     <= '0;
        vbuf_left <= '0;
      end
      if (w_hs) begin
        sram_waddr_w <= w_cnt;
        sram_wdata_w <= in_data;
        w_cnt        <= w_last_hs ? '0 : w_cnt + 1'b1;
      end
      // A new beat emits its first byte straight away; the rest drain from the buffer.
      if (v_hs) begin
        sram_write_enable_v <= 1'b1;
        sram_waddr_v        <= v_cnt;
        sram_wdata_v        <= in_byte;
        vbuf_dat            <= in_rest;
        vbuf_left           <= RW'(BYTES - 1);
        v_cnt               <= v_cnt + 1'b1;
      end else if (!vbuf_empty) begin
        sram_write_enable_v <= 1'b1;
        sram_waddr_v        <= v_cnt;
        sram_wdata_v        <= buf_byte;
        vbuf_dat            <= buf_rest;
        vbuf_left           <= vbuf_left - 1'b1;
        v_cnt               <= v_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpu_sram_loader.sv
module tb_tpu_sram_loader;

  logic        clk = 1'b0, srst = 1'b1, load_start = 1'b0, in_valid = 1'b0, tpu_done = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, we_w, we_v, tpu_start, busy, load_done;
  logic [5:0]  waddr_w;
  logic [63:0] wdata_w;
  logic [4:0]  waddr_v;
  logic [7:0]  wdata_v;

  int checks = 0, errors = 0;
  int w_run = 0, w_run_last = 0;
  bit prev_last_v = 1'b0;

  typedef struct {
    int          kind;   // 0 weight write, 1 vector write, 2 tpu_start, 3 load_done
    int          addr;
    logic [63:0] data;
  } ev_t;
  ev_t exp_q[$];
  logic [63:0] vb [4];

  tpu_sram_loader dut (
    .clk(clk), .srst(srst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sram_write_enable_w(we_w), .sram_waddr_w(waddr_w), .sram_wdata_w(wdata_w),
    .sram_write_enable_v(we_v), .sram_waddr_v(waddr_v), .sram_wdata_v(wdata_v),
    .tpu_start(tpu_start), .tpu_done(tpu_done), .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int a, input logic [63:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input int k, input int a, input logic [63:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event addr %0d data %0h, expected no event", name, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data !== d) begin
        errors++;
        $display("FAIL %s: got kind %0d addr %0d data %0h expected kind %0d addr %0d data %0h",
                 name, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  function automatic logic [63:0] exp_byte(input logic [63:0] d, input int k);
`ifdef LOADER_VBYTE_MSB_FIRST_EN
    return (d >> (56 - 8 * k)) & 64'hff;
`else
    return (d >> (8 * k)) & 64'hff;
`endif
  endfunction

  // Monitor: every DUT output event pops the scoreboard.
  always @(negedge clk) begin
    if (!srst) begin
      if (we_w || we_v) chk("we_exclusive", {we_w, we_v}, 2'b00 | {1'b0, we_w ^ we_v} << (we_w ? 1 : 0));
      if (we_w) pop_cmp("sb_w", 0, int'(waddr_w), wdata_w);
      if (we_v) pop_cmp("sb_v", 1, int'(waddr_v), {56'b0, wdata_v});
      if (tpu_start) begin
        pop_cmp("sb_start", 2, 0, 64'd0);
        chk("start_after_last_v", prev_last_v, 1'b1);
      end
      if (load_done) pop_cmp("sb_done", 3, 0, 64'd0);
      prev_last_v = we_v && (waddr_v == 5'd31);
      if (we_w) w_run++;
      else begin
        if (w_run != 0) w_run_last = w_run;
        w_run = 0;
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, output int waits);
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    done     = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else waits++;
    end
    if (!done) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_load(input bit toggle, input int finish_wait);
    int          waits;
    logic [63:0] d;
    bit          found;
    w_run_last = 0;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      d = toggle ? {32'hC0DE_0000 | 32'(i), 32'(i * 3)} : 64'(i);
      push(0, i, d);
      send_beat(d, waits);
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) push(1, b * 8 + k, exp_byte(vb[b], k));
      if (b == 3) push(2, 0, 64'd0);
      send_beat(vb[b], waits);
      if (b > 0) chk("v_ready_low_cycles", waits, 7);
    end
    if (!toggle) chk("w_consecutive", w_run_last, 64);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (tpu_start) found = 1'b1;
    end
    chk("start_seen", found, 1'b1);
    repeat (finish_wait) @(posedge clk);
    #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    @(negedge clk);
    chk("busy_wait_done", busy, 1'b1);
    chk("ready_wait_done", in_ready, 1'b0);
    @(posedge clk); #1 tpu_done = 1'b1;
    push(3, 0, 64'd0);
    @(negedge clk);
    chk("busy_at_done", busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
    @(posedge clk); #1 tpu_done = 1'b0;
  endtask

  initial begin
    int waits;
    #3;
    chk("reset_outputs", {we_w, waddr_w, wdata_w, we_v, waddr_v, wdata_v, tpu_start, busy, load_done, in_ready}, '0);
    #9 srst = 1'b0;

    // tpu_done outside WAIT_DONE must not produce load_done
    @(posedge clk); #1 tpu_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 tpu_done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored_busy", busy, 1'b0);

    // Abort a weight load after 10 beats
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(0, i, 64'(i) + 64'h100);
      send_beat(64'(i) + 64'h100, waits);
    end
    srst = 1'b1;
    #1;
    chk("srst_async_outputs", {we_w, waddr_w, wdata_w, we_v, waddr_v, wdata_v, tpu_start, busy, load_done, in_ready}, '0);
    exp_q.delete();
    #20 srst = 1'b0;

    // Full load with continuous valid; 100 idle cycles waiting for tpu_done
    for (int b = 0; b < 4; b++) vb[b] = 64'h0706050403020100 + 64'(b) * 64'h0808080808080808;
    do_load(1'b0, 100);

    // Toggled valid during weights; byte-order probe beat first
    vb[0] = 64'h0001020304050607;
    vb[1] = 64'h1122334455667788;
    vb[2] = 64'h8899AABBCCDDEEFF;
    vb[3] = 64'hDEADBEEFCAFEF00D;
    do_load(1'b1, 5);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
